// File: rtl/xor_gate_arbiter_if.sv
// ----------------------------------------------------------------------------
// xor_gate_arbiter_if
//
// Purpose: groups the request and response signals of xor_gate_arbiter.
//
// Handshake (applies to both the request and the response channel): a
// transfer happens on a rising clock edge where valid and ready are both
// high. The producer keeps valid and its data stable until the transfer
// happens. valid never depends on ready. ready may depend combinationally
// on valid.
//
// Signals:
//   req_valid  [N]      requester k presents an operand (bit k)
//   req_data   [2N]     requester k operand in bits [2k+1:2k]
//   req_ready  [N]      one-hot grant, or zero
//   resp_valid          output register holds a result
//   resp_data           XOR result
//   resp_id    [ID_W]   requester that produced resp_data
//   resp_ready          consumer takes the response this cycle
//   resp_count [CNT_W]  completed responses, wraps modulo 2^CNT_W
//
// Modports: master = requesters plus consumer, slave = arbiter.
// ----------------------------------------------------------------------------
interface xor_gate_arbiter_if #(
    parameter int N     = 4,
    parameter int ID_W  = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_W = 16
);
    logic [N-1:0]     req_valid;
    logic [2*N-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic             resp_data;
    logic [ID_W-1:0]  resp_id;
    logic             resp_ready;
    logic [CNT_W-1:0] resp_count;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_count
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_count
    );
endinterface

// File: rtl/xor_gate_arbiter.sv
// ----------------------------------------------------------------------------
// xor_gate_arbiter
//
// Purpose: round-robin arbiter sharing one 2-input XOR kernel among N
// requesters. At most one request is accepted per cycle. The result is
// registered in a single-entry output stage, tagged with the requester ID,
// and held until the consumer accepts it. Completed responses are counted.
//
// Ports:
//   clock      sole clock, rising edge
//   reset_n    asynchronous assert, active-low reset
//   bus        xor_gate_arbiter_if.slave (request and response channels)
//   state_dbg  1 when the output stage is FULL
//   ptr_dbg    current highest-priority requester index
// ----------------------------------------------------------------------------
module xor_gate_arbiter #(
    parameter int N     = 4,
    parameter int ID_W  = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    xor_gate_arbiter_if.slave bus,
    output logic              state_dbg,
    output logic [ID_W-1:0]   ptr_dbg
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  win;
    logic             win_xor;
    logic             found;
    logic             can_accept;
    logic             grant;
    logic             drain;
    logic             resp_data_q;
    logic [ID_W-1:0]  resp_id_q;
    logic [CNT_W-1:0] resp_count_q;
    int               idx;

    // Rotating search starting at ptr_q; the first valid requester wins.
    // The winner's operand is selected here so the kernel sees only it.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_xor = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                win     = ID_W'(idx);
                win_xor = bus.req_data[2*idx] ^ bus.req_data[2*idx+1];
            end
        end
    end

    // A held result leaving this cycle frees the stage for a new grant.
    assign can_accept = (state_q == EMPTY) || bus.resp_ready;
    assign grant      = can_accept && found && reset_n;
    assign drain      = (state_q == FULL) && bus.resp_ready;

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = FULL;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register and priority pointer move only on a grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_data_q <= 1'b0;
            resp_id_q   <= '0;
            ptr_q       <= '0;
        end else if (grant) begin
            resp_data_q <= win_xor;
            resp_id_q   <= win;
            if (win == ID_W'(N - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= win + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_count_q <= '0;
        end else if (drain) begin
            resp_count_q <= resp_count_q + 1'b1;
        end
    end

    assign bus.resp_valid = (state_q == FULL);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_count = resp_count_q;
    assign state_dbg      = (state_q == FULL);
    assign ptr_dbg        = ptr_q;

endmodule

// File: doc/xor_gate_arbiter.md
# xor_gate_arbiter

Round-robin arbiter that shares one XOR gate kernel (2-bit input, 1-bit output, o = i[0] ^ i[1]) among N requesters. It sits in front of the XOR datapath and accepts at most one request per cycle over a valid/ready handshake. It returns a registered result tagged with the requester ID through a single-entry, backpressurable output stage. It also counts completed responses for status readback.

## Interface
- N, default 4: number of requesters; N >= 2.
- ID_W, default clog2(N): width of the requester ID.
- CNT_W, default 16: width of the response counter.

- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N  bit k: requester k presents an operand.
- req_data  in  2N  bits [2k+1:2k] are requester k's operand. Bit 2k feeds kernel bit 0; bit 2k+1 feeds kernel bit 1.
- req_ready  out  N  one-hot or zero; bit k high means requester k is granted this cycle.
- resp_valid  out  1  output register holds a result.
- resp_data  out  1  XOR result.
- resp_id  out  ID_W  index of the requester that produced resp_data.
- resp_ready  in  1  consumer accepts the response this cycle.
- resp_count  out  CNT_W  number of completed responses (resp_valid && resp_ready), modulo 2^CNT_W.

## Operation
- State machine on resp_valid:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- Round-robin pointer ptr (ID_W bits) holds the highest-priority index.
- Winner w: first k with req_valid[k]=1, searching ptr, ptr+1, … N-1, 0, … ptr-1.
- can_accept = (state==EMPTY) || resp_ready.
- req_ready[w] = can_accept && reset_n && any(req_valid). All other bits are 0.
- req_ready may depend combinationally on req_valid. req_valid must not depend on req_ready.
- Grant (req_valid[w] && req_ready[w]), on the next edge:
  - resp_data <= req_data[2w] ^ req_data[2w+1].
  - resp_id <= w.
  - state <= FULL.
  - ptr <= (w==N-1) ? 0 : w+1.
- No grant while FULL with resp_ready=1: state <= EMPTY. resp_data and resp_id keep their last values.
- FULL with resp_ready=0: resp_data and resp_id hold stable; no grant is issued; ptr holds.
- Simultaneous drain and grant (FULL, resp_ready=1, some req_valid): the new result replaces the old with no bubble, and state stays FULL.
- ptr changes only on a grant. A requester that drops req_valid before being granted is skipped without penalty.
- resp_count increments by 1 on every edge where resp_valid && resp_ready, and wraps from 2^CNT_W-1 to 0.
- Arithmetic is pure 1-bit XOR. Any req_data bit of an ungranted requester is ignored.

## Timing
- Reset (reset_n low, asynchronous assertion) drives:
  - state=EMPTY, resp_valid=0, resp_data=0, resp_id=0;
  - ptr=0, resp_count=0;
  - req_ready=0 (forced combinationally while reset_n is low).
- Deassertion is taken synchronously. The first grant is possible in the first cycle with reset_n high.
- Reset mid-operation: a held response is discarded and not counted. A request presented in the reset cycle is not granted.
- Latency: grant in cycle t, so resp_valid=1 with the result at cycle t+1.
- Throughput: 1 response per cycle while resp_ready stays high.
- Fairness: with all N requesters continuously valid and resp_ready=1, grants rotate 0,1,…,N-1,0. Each requester waits at most N-1 grants.
- Backpressure: while FULL and resp_ready=0, req_ready=0 every cycle.

## Test plan
- Reset then single request, N=4: req_valid=0b0100 with req_data[5:4]=2'b10 → req_ready=0b0100 the same cycle. Next cycle resp_valid=1, resp_data=1, resp_id=2, ptr=3.
- Full truth table through requester 0: operands 00, 10, 01, 11 on consecutive cycles with resp_ready=1 → resp_data sequence 0,1,1,0 with no bubbles. resp_count=4 afterwards.
- Fairness: all req_valid=1 and resp_ready=1 for 8 cycles → resp_id sequence 0,1,2,3,0,1,2,3. Each cycle exactly one req_ready bit is set.
- Backpressure: enter FULL with resp_id=1, resp_data=1, then hold resp_ready=0 for 3 cycles with requests pending → req_ready=0, and resp_data/resp_id stay unchanged. Raise resp_ready → same-cycle grant of requester 2, and the new result appears the next cycle.
- Reset mid-operation: while FULL with resp_count=5, pulse reset_n low between edges → resp_valid, resp_data, resp_id, req_ready and resp_count all 0 immediately. After release, ptr=0 and requester 0 wins first.
- Counter wrap with CNT_W=4: 17 completed responses → resp_count=1.
